// File: rtl/pairing_uart_seq.sv
// Pairing-core sequencer: starts the core, times its latency, then
// streams a window of result words out over a byte-wide UART port.
module pairing_uart_seq #(
  parameter int unsigned DATA_W  = 384,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 32'd1 << 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W-1:0] dump_len,
  output logic              core_start,
  input  logic              core_done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              timeout_err,
  output logic              overrun_err,
  output logic [31:0]       cycle_cnt
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_B = BW'(NB - 1);
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RD,
    S_LOAD,
    S_SEND,
    S_NEXT
  } state_e;

  state_e            state_q;
  logic              run_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BW-1:0]     byte_q;
  logic [DATA_W-1:0] sr_q;
  logic [31:0]       cnt_q;
  logic [31:0]       cyc_q;
  logic              start_q;
  logic              rd_q;
  logic              txv_q;
  logic              to_q;
  logic              ov_q;

  logic              run_edge;
  logic [31:0]       cnt_d;
  logic [ADDR_W-1:0] idx_d;
  logic              more;
  logic              fire;
  logic              last;

  assign run_edge = run & ~run_q;
  assign cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
  assign idx_d    = idx_q + 1'b1;
  assign more     = idx_d < len_q;
  assign fire     = txv_q & tx_ready;
  assign last     = byte_q == LAST_B;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      byte_q  <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      start_q <= 1'b0;
      rd_q    <= 1'b0;
      txv_q   <= 1'b0;
      to_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      run_q   <= run;
      start_q <= 1'b0;
      rd_q    <= 1'b0;
      if (run_edge && state_q != S_IDLE)
        ov_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (run_edge) begin
            base_q  <= dump_base;
            len_q   <= dump_len;
            to_q    <= 1'b0;
            ov_q    <= 1'b0;
            start_q <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          // a completion in the timeout cycle still counts as success
          if (core_done) begin
            cyc_q <= cnt_d;
            idx_q <= '0;
            if (len_q != '0) begin
              rd_q    <= 1'b1;
              addr_q  <= base_q;
              state_q <= S_RD;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (cnt_d >= TO_LIM) begin
            to_q    <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_RD: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          sr_q    <= mem_rdata;
          byte_q  <= '0;
          txv_q   <= 1'b1;
          state_q <= S_SEND;
        end
        S_SEND: begin
          if (fire) begin
            sr_q   <= sr_q >> 8;
            byte_q <= byte_q + 1'b1;
            if (last) begin
              txv_q   <= 1'b0;
              state_q <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          idx_q <= idx_d;
          if (more) begin
            rd_q    <= 1'b1;
            addr_q  <= base_q + idx_d;
            state_q <= S_RD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // reset forces every output low in the same cycle it is asserted
  assign core_start  = start_q & ~rst;
  assign mem_rd      = rd_q & ~rst;
  assign mem_addr    = (rst || !rd_q) ? '0 : addr_q;
  assign tx_valid    = txv_q & ~rst;
  assign tx_data     = rst ? 8'h00 : sr_q[7:0];
  assign busy        = (state_q != S_IDLE) & ~rst;
  assign timeout_err = to_q & ~rst;
  assign overrun_err = ov_q & ~rst;
  assign cycle_cnt   = rst ? 32'd0 : cyc_q;

endmodule
